pll_reset_sequencer: RTL

//  Sits directly downstream of the rPLL. Clocked by the PLL output clock (148.5 MHz), it consumes the asynchronous
//  PLL lock and produces a clean, registered reset and a power-up-complete flag for the PSRAM controller domain.

---
 rtl/pll_reset_sequencer_if.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Groups the lock input, the clear strobe and the status outputs of
//   pll_reset_sequencer. Signal prefixes are from the sequencer's point of view.
//   Macro PLL_LOSS_CNT_EN adds the 8-bit o_loss_cnt status signal.
//   Ports:
//     i_pll_lock   PLL lock, asynchronous to the sequencer clock
//     i_clr_lost   one-cycle pulse clearing o_lock_lost
//     o_sys_rst    registered active-high reset for the downstream domain
//     o_ready      registered power-up-wait-complete flag
//     o_lock_lost  sticky lock-loss flag
//     o_state      current FSM state (debug)
//     o_loss_cnt   saturating lock-loss event count (PLL_LOSS_CNT_EN only)
//   Modports: master = the side that drives the lock and the clear strobe, slave = the sequencer.
interface pll_reset_sequencer_if;
  logic       i_pll_lock;
  logic       i_clr_lost;
  logic       o_sys_rst;
  logic       o_ready;
  logic       o_lock_lost;
  logic [2:0] o_state;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] o_loss_cnt;

  modport master (output i_pll_lock, i_clr_lost,
                  input  o_sys_rst, o_ready, o_lock_lost, o_state, o_loss_cnt);
  modport slave  (input  i_pll_lock, i_clr_lost,
                  output o_sys_rst, o_ready, o_lock_lost, o_state, o_loss_cnt);
`else
  modport master (output i_pll_lock, i_clr_lost,
                  input  o_sys_rst, o_ready, o_lock_lost, o_state);
  modport slave  (input  i_pll_lock, i_clr_lost,
                  output o_sys_rst, o_ready, o_lock_lost, o_state);
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Runs in the PLL output clock domain. Synchronises and filters the PLL lock,
//   holds the downstream reset for a few cycles, releases it, then times the
//   PSRAM power-up wait before raising ready. Losing lock after reset release
//   re-asserts reset, flags the loss and restarts the sequence.
//   Macro PLL_LOSS_CNT_EN: adds a saturating 8-bit lock-loss event counter.
//   Ports:
//     i_clk   PLL output clock
//     i_rst   synchronous active-high reset
//     bus     pll_reset_sequencer_if.slave (lock, clear strobe, status)
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   RESET   0  | after i_rst; leaves on the next edge
//   WAIT_LOCK 1| sys_rst high, waiting for synchronised lock
//   FILTER  2  | counting consecutive lock-high cycles
//   HOLD    3  | lock filtered, sys_rst still held
//   POWERUP 4  | sys_rst released, timing the power-up wait
//   RUN     5  | ready; any lock drop restarts from WAIT_LOCK
module pll_reset_sequencer #(
  parameter int SYNC_STAGES      = 2,
  parameter int LOCK_FILT_CYCLES = 256,
  parameter int HOLD_CYCLES      = 16,
  parameter int POWERUP_CYCLES   = 22275,
  parameter int CNT_W            = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pll_reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_POWERUP   = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] L_FILT_LAST = CNT_W'(LOCK_FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic                   r_lock_lost;
  logic                   w_lock_s;
  logic                   w_loss_evt;

  assign w_lock_s   = r_sync[SYNC_STAGES-1];
  // Only a drop after sys_rst release counts as a loss; drops while filtering
  // or holding just restart the sequence silently.
  assign w_loss_evt = ((r_state == ST_POWERUP) || (r_state == ST_RUN)) && !w_lock_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_pll_lock};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_RESET;
      r_cnt     <= '0;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state   <= ST_WAIT_LOCK;
          r_cnt     <= '0;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
        ST_WAIT_LOCK: begin
          r_cnt     <= '0;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
          if (w_lock_s) r_state <= ST_FILTER;
        end
        ST_FILTER: begin
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
          if (!w_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == L_FILT_LAST) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + L_CNT_ONE;
          end
        end
        ST_HOLD: begin
          r_ready <= 1'b0;
          if (!w_lock_s) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
          end else if (r_cnt == L_HOLD_LAST) begin
            r_state   <= ST_POWERUP;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
          end else begin
            r_cnt     <= r_cnt + L_CNT_ONE;
            r_sys_rst <= 1'b1;
          end
        end
        ST_POWERUP: begin
          if (!w_lock_s) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
          end else if (r_cnt == L_PWR_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + L_CNT_ONE;
          end
        end
        ST_RUN: begin
          r_cnt <= '0;
          if (!w_lock_s) begin
            r_state   <= ST_WAIT_LOCK;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_RESET;
          r_cnt     <= '0;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Set beats clear when a loss and a clear strobe land on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_lost <= 1'b0;
    end else if (w_loss_evt) begin
      r_lock_lost <= 1'b1;
    end else if (bus.i_clr_lost) begin
      r_lock_lost <= 1'b0;
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  // Counts every loss event, saturates, and ignores the clear strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign bus.o_loss_cnt = r_loss_cnt;
`else
  // Loss counter not built.
`endif

  assign bus.o_sys_rst   = r_sys_rst;
  assign bus.o_ready     = r_ready;
  assign bus.o_lock_lost = r_lock_lost;
  assign bus.o_state     = r_state;

endmodule
